pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage MIPS core. It generalises the fixed E→M register: the payload width and channel count are configurable, and it adds hold (stall) and flush (bubble) control. The Tnew countdown continues while an instruction is held. It also produces a registered-side forwarding-ready flag and a hold-cycle counter. One instance is placed between each pair of stages (D/E, E/M, M/W).

---
 rtl/pipe_stage_reg_pkg.sv | 7 +
 rtl/pipe_stage_reg_tnew_counter.sv | 27 ++
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared instruction-type codes and default widths for the pipeline registers
package pipe_stage_reg_pkg;
   localparam int          TNEW_W_DEF   = 3;
   localparam int          TYPE_W_DEF   = 8;
   localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
   localparam logic [7:0]  TYPE_NOP     = 8'h3F;
endpackage

// File: rtl/pipe_stage_reg_tnew_counter.sv
// tnew_counter: registered saturating down-counter tracking cycles until a result is produced
import pipe_stage_reg_pkg::*;

module tnew_counter #(
   parameter int TNEW_W = TNEW_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [TNEW_W-1:0] load_val,
   input  logic              clear,
   output logic [TNEW_W-1:0] cnt_o
);
   logic [TNEW_W-1:0] cnt_d, cnt_q, src;

   // a freshly loaded value is already one stage further on, so it is decremented too
   always_comb begin
      src   = load ? load_val : cnt_q;
      cnt_d = clear ? '0 : (src == '0) ? '0 : src - TNEW_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;

   assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with hold, flush, Tnew countdown and forward-ready flag
import pipe_stage_reg_pkg::*;

module pipe_stage_reg #(
   parameter int                DATA_W   = 32,
   parameter int                NUM_DATA = 2,
   parameter int                CTRL_W   = 4,
   parameter int                TYPE_W   = TYPE_W_DEF,
   parameter int                TNEW_W   = TNEW_W_DEF,
   parameter logic [31:0]       PC_RESET = PC_RESET_DEF,
   parameter logic [TYPE_W-1:0] NOP_TYPE = TYPE_W'(TYPE_NOP)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       en,
   input  logic                       flush,
   input  logic [31:0]                pc_i,
   input  logic [NUM_DATA*DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0]          ctrl_i,
   input  logic [TYPE_W-1:0]          type_i,
   input  logic [TNEW_W-1:0]          tnew_i,
   input  logic [4:0]                 wr_i,
   input  logic [4:0]                 addr_i,
   output logic [31:0]                pc_o,
   output logic [NUM_DATA*DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0]          ctrl_o,
   output logic [TYPE_W-1:0]          type_o,
   output logic [TNEW_W-1:0]          tnew_o,
   output logic [4:0]                 wr_o,
   output logic [4:0]                 addr_o,
   output logic                       valid_o,
   output logic                       ready_o,
   output logic [7:0]                 hold_cnt_o
);
   logic [31:0]                pc_d, pc_q;
   logic [NUM_DATA*DATA_W-1:0] data_d, data_q;
   logic [CTRL_W-1:0]          ctrl_d, ctrl_q;
   logic [TYPE_W-1:0]          type_d, type_q;
   logic [4:0]                 wr_d, wr_q, addr_d, addr_q;
   logic                       valid_d, valid_q;
   logic [7:0]                 hold_d, hold_q;

   tnew_counter #(.TNEW_W(TNEW_W)) u_tnew (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (en),
      .load_val (tnew_i),
      .clear    (flush),
      .cnt_o    (tnew_o)
   );

   // a bubble keeps the upstream PC so later exception logic can attribute it
   always_comb begin
      pc_d    = (flush || en) ? pc_i : pc_q;
      data_d  = flush ? '0 : en ? data_i : data_q;
      ctrl_d  = flush ? '0 : en ? ctrl_i : ctrl_q;
      type_d  = flush ? NOP_TYPE : en ? type_i : type_q;
      wr_d    = flush ? '0 : en ? wr_i : wr_q;
      addr_d  = flush ? '0 : en ? addr_i : addr_q;
      valid_d = flush ? 1'b0 : en ? 1'b1 : valid_q;
      hold_d  = (flush || en) ? 8'd0 : (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pc_q    <= PC_RESET;
         data_q  <= '0;
         ctrl_q  <= '0;
         type_q  <= NOP_TYPE;
         wr_q    <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         type_q  <= type_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
      end

   assign pc_o       = pc_q;
   assign data_o     = data_q;
   assign ctrl_o     = ctrl_q;
   assign type_o     = type_q;
   assign wr_o       = wr_q;
   assign addr_o     = addr_q;
   assign valid_o    = valid_q;
   assign hold_cnt_o = hold_q;
   assign ready_o    = valid_q && (wr_q != 5'd0) && (tnew_o == '0);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of load, hold countdown, flush priority, saturation and reset
`timescale 1ns/1ps
module tb_pipe_stage_reg;
  localparam logic [7:0] NOP = 8'h3F;
  logic        clk = 1'b0, reset_n = 1'b1, en = 1'b0, flush = 1'b0;
  logic [31:0] pc_i = '0, pc_o;
  logic [63:0] data_i = '0, data_o;
  logic [3:0]  ctrl_i = '0, ctrl_o;
  logic [7:0]  type_i = '0, type_o;
  logic [2:0]  tnew_i = '0, tnew_o;
  logic [4:0]  wr_i = '0, wr_o, addr_i = '0, addr_o;
  logic        valid_o, ready_o;
  logic [7:0]  hold_cnt_o;
  int          total = 0, bad = 0;
  pipe_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
    .pc_i(pc_i), .data_i(data_i), .ctrl_i(ctrl_i), .type_i(type_i),
    .tnew_i(tnew_i), .wr_i(wr_i), .addr_i(addr_i),
    .pc_o(pc_o), .data_o(data_o), .ctrl_o(ctrl_o), .type_o(type_o),
    .tnew_o(tnew_o), .wr_o(wr_o), .addr_o(addr_o),
    .valid_o(valid_o), .ready_o(ready_o), .hold_cnt_o(hold_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_pc", pc_o, 32'h0000_3000);
    chk("rst_type", type_o, NOP);
    chk("rst_data", data_o, 64'd0);
    chk("rst_ctrl", ctrl_o, 4'd0);
    chk("rst_wr", wr_o, 5'd0);
    chk("rst_addr", addr_o, 5'd0);
    chk("rst_tnew", tnew_o, 3'd0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_hold", hold_cnt_o, 8'd0);
    chk("rst_ready", ready_o, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1; pc_i = 32'h3004; data_i = {32'hDEAD_BEEF, 32'h1234_5678};
    ctrl_i = 4'hA; type_i = 8'h21; wr_i = 5'd8; addr_i = 5'd5; tnew_i = 3'd2;
    step();
    chk("ld_pc", pc_o, 32'h3004);
    chk("ld_data", data_o, {32'hDEAD_BEEF, 32'h1234_5678});
    chk("ld_ctrl", ctrl_o, 4'hA);
    chk("ld_type", type_o, 8'h21);
    chk("ld_wr", wr_o, 5'd8);
    chk("ld_addr", addr_o, 5'd5);
    chk("ld_tnew", tnew_o, 3'd1);
    chk("ld_valid", valid_o, 1'b1);
    chk("ld_ready", ready_o, 1'b0);
    chk("ld_hold", hold_cnt_o, 8'd0);
    en = 1'b0; pc_i = 32'h5555; data_i = '1; wr_i = 5'd1; tnew_i = 3'd7;
    step();
    chk("h1_tnew", tnew_o, 3'd0);
    chk("h1_ready", ready_o, 1'b1);
    chk("h1_hold", hold_cnt_o, 8'd1);
    repeat (2) step();
    chk("h3_tnew", tnew_o, 3'd0);
    chk("h3_ready", ready_o, 1'b1);
    chk("h3_hold", hold_cnt_o, 8'd3);
    chk("h3_data", data_o, {32'hDEAD_BEEF, 32'h1234_5678});
    chk("h3_pc", pc_o, 32'h3004);
    chk("h3_wr", wr_o, 5'd8);
    flush = 1'b1; en = 1'b1; pc_i = 32'h3010; wr_i = 5'd9; tnew_i = 3'd3;
    step();
    chk("fl_valid", valid_o, 1'b0);
    chk("fl_wr", wr_o, 5'd0);
    chk("fl_type", type_o, NOP);
    chk("fl_pc", pc_o, 32'h3010);
    chk("fl_hold", hold_cnt_o, 8'd0);
    chk("fl_data", data_o, 64'd0);
    chk("fl_ctrl", ctrl_o, 4'd0);
    chk("fl_tnew", tnew_o, 3'd0);
    chk("fl_ready", ready_o, 1'b0);
    flush = 1'b0; en = 1'b1; pc_i = 32'h3014; wr_i = 5'd0; tnew_i = 3'd0; type_i = 8'h22;
    step();
    chk("r0_valid", valid_o, 1'b1);
    chk("r0_tnew", tnew_o, 3'd0);
    chk("r0_ready", ready_o, 1'b0);
    wr_i = 5'd3; pc_i = 32'h3018;
    step();
    chk("r3_ready", ready_o, 1'b1);
    wr_i = 5'd4; tnew_i = 3'd3; data_i = 64'h0123_4567_89AB_CDEF; pc_i = 32'h301C;
    step();
    chk("t3_tnew", tnew_o, 3'd2);
    chk("t3_ready", ready_o, 1'b0);
    en = 1'b0;
    step();
    chk("t3h_tnew", tnew_o, 3'd1);
    chk("t3h_ready", ready_o, 1'b0);
    repeat (299) step();
    chk("sat_hold", hold_cnt_o, 8'd255);
    chk("sat_tnew", tnew_o, 3'd0);
    chk("sat_data", data_o, 64'h0123_4567_89AB_CDEF);
    chk("sat_valid", valid_o, 1'b1);
    chk("sat_ready", ready_o, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_hold", hold_cnt_o, 8'd0);
    chk("mr_pc", pc_o, 32'h0000_3000);
    chk("mr_valid", valid_o, 1'b0);
    chk("mr_data", data_o, 64'd0);
    chk("mr_type", type_o, NOP);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("pr_hold", hold_cnt_o, 8'd1);
    chk("pr_valid", valid_o, 1'b0);
    if (bad != 0) $error("FAIL summary: %0d of %0d checks failed", bad, total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
